// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer: the FSM state type with its
// fixed encodings and the width/limit of the optional lock-loss counter.
// No ports (package).
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_STABLE  = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_e;

    localparam int unsigned LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for signals asynchronous to clk_i.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears both flop ranks
//   d_i    - asynchronous input bits
//   q_o    - synchronized output bits (two clk_i edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Holds downstream blocks in reset until the PLL has been locked for
// STABLE_CYCLES consecutive cycles, then releases N_STAGES reset outputs one
// after another, STAGE_GAP cycles apart, and finally raises ready_o. Loss of
// lock or a software reset request restarts the whole sequence.
//
// Ports:
//   clk_i           - divided PLL clock, all logic on rising edge
//   rst_i           - asynchronous active-high reset
//   locked_i        - PLL lock, asynchronous (synchronized internally)
//   sw_rst_i        - synchronous level-sensitive software reset request
//   rst_stage_o     - active-high staged resets, bit 0 released first
//   ready_o         - all stages released, sequence complete
//   state_o         - current FSM state encoding
//   lock_loss_cnt_o - (only with RST_SEQ_LOSS_CNT_EN) saturating count of
//                     restarts caused by lock loss, cleared only by rst_i
//
// Build option: define RST_SEQ_LOSS_CNT_EN to add lock_loss_cnt_o.
// ---------------------------------------------------------------------------
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES      = 3,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                locked_i,
    input  logic                sw_rst_i,
    output logic [N_STAGES-1:0] rst_stage_o,
    output logic                ready_o,
    output logic [1:0]          state_o
`ifdef RST_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]          lock_loss_cnt_o
`endif
);

    localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    logic locked_s;

    state_e              state_q,     state_d;
    logic [N_STAGES-1:0] rst_stage_q, rst_stage_d;
    logic                ready_q,     ready_d;
    logic [STAB_W-1:0]   stab_cnt_q,  stab_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q,   gap_cnt_d;
`ifdef RST_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

    logic abort;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (locked_i),
        .q_o   (locked_s)
    );

    assign abort = !locked_s || sw_rst_i;

    always_comb begin
        state_d     = state_q;
        rst_stage_d = rst_stage_q;
        ready_d     = ready_q;
        stab_cnt_d  = stab_cnt_q;
        gap_cnt_d   = gap_cnt_q;
`ifdef RST_SEQ_LOSS_CNT_EN
        loss_cnt_d  = loss_cnt_q;
`endif

        if (state_q != S_RESET && abort) begin
            // Restart from any active state; lock loss and software reset
            // together still count as a single lock-loss restart.
            state_d     = S_RESET;
            rst_stage_d = '1;
            ready_d     = 1'b0;
            stab_cnt_d  = '0;
            gap_cnt_d   = '0;
`ifdef RST_SEQ_LOSS_CNT_EN
            if (!locked_s && loss_cnt_q != LOSS_CNT_MAX) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_RESET: begin
                    rst_stage_d = '1;
                    ready_d     = 1'b0;
                    stab_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    if (!abort) begin
                        state_d = S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (stab_cnt_q == STAB_LAST) begin
                        // Stage 0 is released on the very edge that enters
                        // S_RELEASE.
                        state_d     = S_RELEASE;
                        stab_cnt_d  = '0;
                        rst_stage_d = {N_STAGES{1'b1}} << 1;
                    end else if (stab_cnt_q != '1) begin
                        stab_cnt_d = stab_cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        // Shifting a zero in from bit 0 releases the next
                        // stage; once all are zero one more gap ends in RUN.
                        if (rst_stage_q == '0) begin
                            state_d = S_RUN;
                            ready_d = 1'b1;
                        end else begin
                            rst_stage_d = rst_stage_q << 1;
                        end
                    end else if (gap_cnt_q != '1) begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_RESET;
            rst_stage_q <= '1;
            ready_q     <= 1'b0;
            stab_cnt_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rst_stage_q <= rst_stage_d;
            ready_q     <= ready_d;
            stab_cnt_q  <= stab_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

`ifdef RST_SEQ_LOSS_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

    assign rst_stage_o = rst_stage_q;
    assign ready_o     = ready_q;
    assign state_o     = state_q;

endmodule
